nabp_map_sequencer: RTL and testbench
=====================================

# nabp_map_sequencer

Sequencer that drives one NABPMapper/shifter pair through a full back-projection pass: for each projection angle it fetches the mapper's fixed-point accumulator coefficients from a registered coefficient ROM, presents them, kicks the mapper, issues exactly one projection line of shift enables (throttled by downstream ready), and closes the line with a done strobe. It sits between the top-level state control and the mapper, taking over the `mp_accu_init`/`mp_accu_base` and `sh_kick`/`sh_shift_en`/`sh_done` signalling.

## Interface
Parameters:
- `P_LINE_SIZE`, 256: shift cycles per projection line (≥2).
- `N_ANGLES`, 180: angles per pass (≥1).
- `ANGLE_W`, 8: angle index width; must satisfy 2^ANGLE_W ≥ N_ANGLES.
- `ACCU_W`, 24: width of the signed fixed-point accumulator coefficients.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a pass; ignored unless idle.
- `ds_ready`  in  1  downstream line buffer can accept a sample this cycle.
- `rom_en`  out  1  coefficient ROM read enable.
- `rom_addr`  out  ANGLE_W  coefficient ROM address (= current angle).
- `rom_init`  in  ACCU_W  accumulator init, valid the cycle after `rom_en`.
- `rom_base`  in  ACCU_W  accumulator step, valid the cycle after `rom_en`.
- `mp_accu_init`  out  ACCU_W  registered init to mapper.
- `mp_accu_base`  out  ACCU_W  registered step to mapper.
- `sh_kick`  out  1  one-cycle mapper start.
- `sh_shift_en`  out  1  mapper advance.
- `sh_done`  out  1  one-cycle line end.
- `angle`  out  ANGLE_W  current angle index.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse, pass complete.
- `abort`  in  1  present only with `NABP_SEQ_ABORT_EN`.

## Operation
- States: IDLE, FETCH, LOAD, KICK, SHIFT, LDONE.
- IDLE: `busy`=0. `start` → FETCH, `angle`←0.
- FETCH: `rom_en`=1, `rom_addr`=`angle`; → LOAD.
- LOAD: `mp_accu_init`←`rom_init`, `mp_accu_base`←`rom_base`; → KICK. Coefficients then hold stable until the next LOAD.
- KICK: `sh_kick`=1; shift counter ←0; → SHIFT.
- SHIFT: `sh_shift_en` = `ds_ready` (combinational, SHIFT only). Counter (width clog2(P_LINE_SIZE)) increments on each accepted shift. When a shift is accepted with counter = P_LINE_SIZE-1 → LDONE. Exactly P_LINE_SIZE enables per line.
- LDONE: `sh_done`=1. If `angle`=N_ANGLES-1: `done`=1, → IDLE. Otherwise `angle`←`angle`+1, → FETCH.
- `busy`=1 in every state except IDLE.
- `start` while busy: ignored, no effect on counters.
- `ds_ready` low in SHIFT: `sh_shift_en`=0, counter holds, state holds; no timeout.
- `ds_ready` outside SHIFT: ignored.
- `sh_kick`, `sh_shift_en`, `sh_done`, `rom_en` are mutually exclusive.

## Timing
- Reset (any state, including mid-line): state IDLE, `angle`=0, counter=0, `mp_accu_init`=`mp_accu_base`=0, and all strobes, `busy`, and `done` at 0 from the next edge. No `sh_done` is emitted on reset; the mapper is reset by the same signal.
- `start` at cycle 0: FETCH at cycle 1, LOAD 2, KICK 3, first possible shift at 4.
- With `ds_ready` held high, one line takes P_LINE_SIZE+4 cycles (FETCH through LDONE). A pass takes N_ANGLES·(P_LINE_SIZE+4) cycles; `done` coincides with the final `sh_done`.
- `busy` is high from cycle 1 through the final LDONE. A new `start` is accepted the cycle after `done`.
- ROM latency is fixed at 1 cycle; no ready or valid signal from the ROM.

## Configuration
- `NABP_SEQ_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in any busy state → next state IDLE, `angle`←0.
  - If aborted in SHIFT or KICK, `sh_done`=1 for that one cycle so the mapper returns to ready; `done` is not pulsed.
  - `abort` in IDLE has no effect. `abort` takes priority over a simultaneous SHIFT completion.
- `NABP_SEQ_ABORT_EN` undefined: no `abort` port; a pass runs to completion or reset only.

## Test plan
- P_LINE_SIZE=4, N_ANGLES=3, `ds_ready`=1, ROM returns init=0x100·k and base=0x10+k at address k → per angle: 1 `rom_en`, `mp_accu_*` match k from KICK onward, 1 `sh_kick`, 4 `sh_shift_en`, 1 `sh_done`. `done` at cycle 24 after `start`; `busy` low at 25.
- Same setup, `ds_ready` low for 3 cycles mid-SHIFT on angle 1 → still exactly 4 enables on angle 1; `done` delayed by 3 cycles to cycle 27.
- `start` pulsed during SHIFT of angle 0 → no restart; `angle` sequence 0,1,2; single `done`.
- `reset` asserted for 1 cycle during SHIFT of angle 1 → all outputs 0 and state IDLE next cycle; no `sh_done` or `done`. A fresh `start` then completes a normal 24-cycle pass.
- N_ANGLES=1, P_LINE_SIZE=2 → `done` at cycle 6, simultaneous with `sh_done`; back-to-back `start` at cycle 7 accepted.
- With `NABP_SEQ_ABORT_EN`, `abort` on the 2nd shift of angle 1 → `sh_done`=1 that cycle, IDLE next, `done` never pulses; without the macro the netlist has no `abort` port.

Source files
------------

// File: rtl/nabp_map_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nabp_map_sequencer
// Purpose  : Runs one NABPMapper/shifter pair through a full back-projection
//            pass. For each angle it reads the accumulator coefficients from
//            a 1-cycle-latency ROM, registers them toward the mapper, kicks
//            the mapper, issues P_LINE_SIZE shift enables throttled by
//            ds_ready, and closes the line with sh_done.
// Ports    : clk, reset (sync, active high), start (pass request),
//            ds_ready (downstream accept), rom_en/rom_addr -> ROM,
//            rom_init/rom_base <- ROM, mp_accu_init/mp_accu_base -> mapper,
//            sh_kick/sh_shift_en/sh_done -> mapper/shifter,
//            angle, busy, done (pass complete pulse),
//            abort (only when NABP_SEQ_ABORT_EN is defined).
// Options  : NABP_SEQ_ABORT_EN - adds the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module nabp_map_sequencer #(
  parameter int P_LINE_SIZE = 256,
  parameter int N_ANGLES    = 180,
  parameter int ANGLE_W     = 8,
  parameter int ACCU_W      = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ds_ready,
`ifdef NABP_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic               rom_en,
  output logic [ANGLE_W-1:0] rom_addr,
  input  logic [ACCU_W-1:0]  rom_init,
  input  logic [ACCU_W-1:0]  rom_base,
  output logic [ACCU_W-1:0]  mp_accu_init,
  output logic [ACCU_W-1:0]  mp_accu_base,
  output logic               sh_kick,
  output logic               sh_shift_en,
  output logic               sh_done,
  output logic [ANGLE_W-1:0] angle,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (P_LINE_SIZE > 1) ? $clog2(P_LINE_SIZE) : 1;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_LOAD  = 3'd2;
  localparam logic [2:0] c_KICK  = 3'd3;
  localparam logic [2:0] c_SHIFT = 3'd4;
  localparam logic [2:0] c_LDONE = 3'd5;

  localparam logic [CNT_W-1:0]   c_LAST_SHIFT = CNT_W'(P_LINE_SIZE - 1);
  localparam logic [ANGLE_W-1:0] c_LAST_ANGLE = ANGLE_W'(N_ANGLES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ANGLE_W-1:0] r_angle;
  logic [ACCU_W-1:0]  r_init;
  logic [ACCU_W-1:0]  r_base;
  logic               w_abort;
  logic               w_last_angle;

  // Abort only acts while a pass is running; in IDLE it is a no-op.
`ifdef NABP_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != c_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_last_angle = (r_angle == c_LAST_ANGLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_FETCH;
      c_FETCH: w_state_nxt = c_LOAD;
      c_LOAD:  w_state_nxt = c_KICK;
      c_KICK:  w_state_nxt = c_SHIFT;
      c_SHIFT: if (ds_ready && (r_cnt == c_LAST_SHIFT)) w_state_nxt = c_LDONE;
      c_LDONE: w_state_nxt = w_last_angle ? c_IDLE : c_FETCH;
      default: w_state_nxt = c_IDLE;
    endcase
    // Abort overrides everything, including a line completing this cycle.
    if (w_abort) w_state_nxt = c_IDLE;
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    rom_en      = 1'b0;
    sh_kick     = 1'b0;
    sh_shift_en = 1'b0;
    sh_done     = 1'b0;
    done        = 1'b0;
    busy        = (r_state != c_IDLE);
    case (r_state)
      c_FETCH: rom_en = 1'b1;
      // An abort once the mapper is (about to be) running ends the line
      // with sh_done instead, so the mapper returns to ready; the strobes
      // stay mutually exclusive.
      c_KICK: begin
        sh_kick = !w_abort;
        sh_done = w_abort;
      end
      c_SHIFT: begin
        sh_shift_en = ds_ready && !w_abort;
        sh_done     = w_abort;
      end
      c_LDONE: begin
        sh_done = 1'b1;
        done    = w_last_angle && !w_abort;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Angle index, shift counter and coefficient registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_angle <= '0;
      r_cnt   <= '0;
      r_init  <= '0;
      r_base  <= '0;
    end else begin
      if (w_abort) begin
        r_angle <= '0;
      end else if ((r_state == c_IDLE) && start) begin
        r_angle <= '0;
      end else if ((r_state == c_LDONE) && !w_last_angle) begin
        r_angle <= r_angle + 1'b1;
      end

      if (r_state == c_KICK) begin
        r_cnt <= '0;
      end else if (sh_shift_en) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // ROM data is valid exactly one cycle after rom_en, i.e. in LOAD.
      if (r_state == c_LOAD) begin
        r_init <= rom_init;
        r_base <= rom_base;
      end
    end
  end

  assign rom_addr     = r_angle;
  assign angle        = r_angle;
  assign mp_accu_init = r_init;
  assign mp_accu_base = r_base;

endmodule
`default_nettype wire

// File: tb/tb_nabp_map_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nabp_map_sequencer
// Purpose  : Scoreboard bench for nabp_map_sequencer. dut_a runs with
//            P_LINE_SIZE=4, N_ANGLES=3; dut_b with P_LINE_SIZE=2, N_ANGLES=1.
//            Stimulus pushes expected strobe events and status snapshots;
//            a single negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nabp_map_sequencer;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic [7:0]  ang;
    logic [23:0] init;
    logic [23:0] base;
  } ev_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        chk_data;
    logic        busy;
    logic [7:0]  ang;
    logic [23:0] init;
    logic [23:0] base;
    logic [4:0]  strb;   // {rom_en, sh_kick, sh_shift_en, sh_done, done}
  } st_t;

  localparam logic [2:0] c_EV_ROM    = 3'd0;
  localparam logic [2:0] c_EV_KICK   = 3'd1;
  localparam logic [2:0] c_EV_SHIFT  = 3'd2;
  localparam logic [2:0] c_EV_LDONE  = 3'd3;
  localparam logic [2:0] c_EV_DONE   = 3'd4;
  localparam logic [2:0] c_EV_ORPHAN = 3'd5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic ds_ready_a = 1'b1, ds_ready_b = 1'b1;
  logic abort_a = 1'b0, abort_b = 1'b0;

  logic        rom_en_a, sh_kick_a, sh_shift_en_a, sh_done_a, busy_a, done_a;
  logic [7:0]  rom_addr_a, angle_a;
  logic [23:0] rom_init_a = '0, rom_base_a = '0, mp_init_a, mp_base_a;
  logic        rom_en_b, sh_kick_b, sh_shift_en_b, sh_done_b, busy_b, done_b;
  logic [7:0]  rom_addr_b, angle_b;
  logic [23:0] rom_init_b = '0, rom_base_b = '0, mp_init_b, mp_base_b;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  bit  fin   = 1'b0;
  ev_t qa[$];
  ev_t qb[$];
  st_t qs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nabp_map_sequencer #(.P_LINE_SIZE(4), .N_ANGLES(3), .ANGLE_W(8), .ACCU_W(24)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ds_ready(ds_ready_a),
`ifdef NABP_SEQ_ABORT_EN
    .abort(abort_a),
`endif
    .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_init(rom_init_a), .rom_base(rom_base_a),
    .mp_accu_init(mp_init_a), .mp_accu_base(mp_base_a),
    .sh_kick(sh_kick_a), .sh_shift_en(sh_shift_en_a), .sh_done(sh_done_a),
    .angle(angle_a), .busy(busy_a), .done(done_a)
  );

  nabp_map_sequencer #(.P_LINE_SIZE(2), .N_ANGLES(1), .ANGLE_W(8), .ACCU_W(24)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ds_ready(ds_ready_b),
`ifdef NABP_SEQ_ABORT_EN
    .abort(abort_b),
`endif
    .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_init(rom_init_b), .rom_base(rom_base_b),
    .mp_accu_init(mp_init_b), .mp_accu_base(mp_base_b),
    .sh_kick(sh_kick_b), .sh_shift_en(sh_shift_en_b), .sh_done(sh_done_b),
    .angle(angle_b), .busy(busy_b), .done(done_b)
  );

  // Coefficient ROMs: init = 0x100*k, base = 0x10+k, one cycle latency.
  always @(posedge clk) begin
    if (rom_en_a) begin
      rom_init_a <= 24'(32'h100 * rom_addr_a);
      rom_base_a <= 24'(32'h10 + rom_addr_a);
    end
    if (rom_en_b) begin
      rom_init_b <= 24'(32'h100 * rom_addr_b);
      rom_base_b <= 24'(32'h10 + rom_addr_b);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  function automatic ev_t mk(input logic [2:0] kind, input int c, input logic [7:0] ang,
                             input logic [23:0] init, input logic [23:0] base);
    ev_t e;
    e.kind = kind; e.cyc = 32'(c); e.ang = ang; e.init = init; e.base = base;
    return e;
  endfunction

  task automatic push_ev(input int which, input logic [2:0] kind, input int c, input int k);
    ev_t e;
    if (kind == c_EV_KICK) e = mk(kind, c, 8'(k), 24'(256 * k), 24'(16 + k));
    else                   e = mk(kind, c, 8'(k), 24'h0, 24'h0);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // One line starting with FETCH at cycle c; 'stall' idle cycles after the first shift.
  task automatic push_line(input int which, input int c, input int k, input int stall,
                           input bit last, input int p, output int nxt);
    int t;
    push_ev(which, c_EV_ROM, c, k);
    push_ev(which, c_EV_KICK, c + 2, k);
    t = c + 3;
    for (int i = 0; i < p; i++) begin
      push_ev(which, c_EV_SHIFT, t, k);
      t++;
      if (i == 0) t += stall;
    end
    push_ev(which, last ? c_EV_DONE : c_EV_LDONE, t, k);
    nxt = t + 1;
  endtask

  task automatic push_pass_a(input int s, input int stall1);
    int f;
    f = s + 1;
    for (int k = 0; k < 3; k++) push_line(0, f, k, (k == 1) ? stall1 : 0, (k == 2), 4, f);
  endtask

  task automatic push_st(input int c, input bit chk, input bit busy, input int ang,
                         input logic [23:0] init, input logic [23:0] base, input logic [4:0] strb);
    st_t s;
    s.cyc = 32'(c); s.chk_data = chk; s.busy = busy; s.ang = 8'(ang);
    s.init = init; s.base = base; s.strb = strb;
    qs.push_back(s);
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic check_ev(input int which, input ev_t act);
    ev_t exp;
    total++;
    if ((which == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
      bad++;
      $display("FAIL ev_dut%0d unexpected: got kind=%0d cyc=%0d ang=%0d init=%h base=%h, required no event",
               which, act.kind, act.cyc, act.ang, act.init, act.base);
    end else begin
      exp = (which == 0) ? qa.pop_front() : qb.pop_front();
      if (act !== exp) begin
        bad++;
        $display("FAIL ev_dut%0d: got kind=%0d cyc=%0d ang=%0d init=%h base=%h, required kind=%0d cyc=%0d ang=%0d init=%h base=%h",
                 which, act.kind, act.cyc, act.ang, act.init, act.base,
                 exp.kind, exp.cyc, exp.ang, exp.init, exp.base);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    st_t    st;
    logic   ok;
    logic [4:0] strb;
    if (fin) begin
      foreach (qa[i]) begin
        total++; bad++;
        $display("FAIL ev_dut0 missing: got nothing, required kind=%0d cyc=%0d ang=%0d", qa[i].kind, qa[i].cyc, qa[i].ang);
      end
      foreach (qb[i]) begin
        total++; bad++;
        $display("FAIL ev_dut1 missing: got nothing, required kind=%0d cyc=%0d ang=%0d", qb[i].kind, qb[i].cyc, qb[i].ang);
      end
      foreach (qs[i]) begin
        total++; bad++;
        $display("FAIL status missing: got nothing, required snapshot at cyc=%0d", qs[i].cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else begin
      if (rom_en_a)      check_ev(0, mk(c_EV_ROM,   cyc, rom_addr_a, 24'h0, 24'h0));
      if (sh_kick_a)     check_ev(0, mk(c_EV_KICK,  cyc, angle_a, mp_init_a, mp_base_a));
      if (sh_shift_en_a) check_ev(0, mk(c_EV_SHIFT, cyc, angle_a, 24'h0, 24'h0));
      if (sh_done_a)     check_ev(0, mk(done_a ? c_EV_DONE : c_EV_LDONE, cyc, angle_a, 24'h0, 24'h0));
      if (done_a && !sh_done_a) check_ev(0, mk(c_EV_ORPHAN, cyc, angle_a, 24'h0, 24'h0));
      if (rom_en_b)      check_ev(1, mk(c_EV_ROM,   cyc, rom_addr_b, 24'h0, 24'h0));
      if (sh_kick_b)     check_ev(1, mk(c_EV_KICK,  cyc, angle_b, mp_init_b, mp_base_b));
      if (sh_shift_en_b) check_ev(1, mk(c_EV_SHIFT, cyc, angle_b, 24'h0, 24'h0));
      if (sh_done_b)     check_ev(1, mk(done_b ? c_EV_DONE : c_EV_LDONE, cyc, angle_b, 24'h0, 24'h0));
      if (done_b && !sh_done_b) check_ev(1, mk(c_EV_ORPHAN, cyc, angle_b, 24'h0, 24'h0));

      strb = {rom_en_a, sh_kick_a, sh_shift_en_a, sh_done_a, done_a};
      while ((qs.size() > 0) && (qs[0].cyc <= 32'(cyc))) begin
        st = qs.pop_front();
        total++;
        ok = (st.cyc == 32'(cyc)) && (busy_a === st.busy) && (strb === st.strb);
        if (st.chk_data)
          ok = ok && (angle_a === st.ang) && (mp_init_a === st.init) && (mp_base_a === st.base);
        if (!ok) begin
          bad++;
          $display("FAIL status cyc=%0d: got busy=%b strb=%b ang=%0d init=%h base=%h, required busy=%b strb=%b ang=%0d init=%h base=%h (data %s)",
                   st.cyc, busy_a, strb, angle_a, mp_init_a, mp_base_a,
                   st.busy, st.strb, st.ang, st.init, st.base, st.chk_data ? "checked" : "ignored");
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stim
    int s;
    int f;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    push_st(cyc, 1'b1, 1'b0, 0, 24'h0, 24'h0, 5'b00000);
    tick(); tick();

    // Normal pass: done at s+24, idle at s+25.
    start_a = 1'b1; s = cyc;
    push_pass_a(s, 0);
    push_st(s + 24, 1'b1, 1'b1, 2, 24'h200, 24'h12, 5'b00011);
    push_st(s + 25, 1'b0, 1'b0, 0, 24'h0, 24'h0, 5'b00000);
    tick(); start_a = 1'b0;
    wait_until(s + 27);

    // ds_ready low for 3 cycles after the first shift of angle 1.
    start_a = 1'b1; s = cyc;
    push_pass_a(s, 3);
    push_st(s + 14, 1'b1, 1'b1, 1, 24'h100, 24'h11, 5'b00000);
    push_st(s + 27, 1'b1, 1'b1, 2, 24'h200, 24'h12, 5'b00011);
    push_st(s + 28, 1'b0, 1'b0, 0, 24'h0, 24'h0, 5'b00000);
    tick(); start_a = 1'b0;
    wait_until(s + 13); ds_ready_a = 1'b0;
    wait_until(s + 16); ds_ready_a = 1'b1;
    wait_until(s + 30);

    // start pulsed during SHIFT of angle 0 is ignored.
    start_a = 1'b1; s = cyc;
    push_pass_a(s, 0);
    tick(); start_a = 1'b0;
    wait_until(s + 5); start_a = 1'b1;
    tick(); start_a = 1'b0;
    wait_until(s + 28);

    // Reset during the 2nd shift of angle 1, then a fresh pass.
    start_a = 1'b1; s = cyc;
    push_line(0, s + 1, 0, 0, 1'b0, 4, f);
    push_ev(0, c_EV_ROM, s + 9, 1);
    push_ev(0, c_EV_KICK, s + 11, 1);
    push_ev(0, c_EV_SHIFT, s + 12, 1);
    push_ev(0, c_EV_SHIFT, s + 13, 1);
    push_st(s + 14, 1'b1, 1'b0, 0, 24'h0, 24'h0, 5'b00000);
    tick(); start_a = 1'b0;
    wait_until(s + 13); reset = 1'b1;
    tick(); reset = 1'b0;
    tick();
    start_a = 1'b1; s = cyc;
    push_pass_a(s, 0);
    push_st(s + 24, 1'b1, 1'b1, 2, 24'h200, 24'h12, 5'b00011);
    tick(); start_a = 1'b0;
    wait_until(s + 27);

    // Single angle, two-shift line; back-to-back start the cycle after done.
    start_b = 1'b1; s = cyc;
    push_line(1, s + 1, 0, 0, 1'b1, 2, f);
    push_line(1, s + 8, 0, 0, 1'b1, 2, f);
    tick(); start_b = 1'b0;
    wait_until(s + 7); start_b = 1'b1;
    tick(); start_b = 1'b0;
    wait_until(s + 17);

`ifdef NABP_SEQ_ABORT_EN
    // Abort on the 2nd shift of angle 1: sh_done that cycle, idle after, no done.
    start_a = 1'b1; s = cyc;
    push_line(0, s + 1, 0, 0, 1'b0, 4, f);
    push_ev(0, c_EV_ROM, s + 9, 1);
    push_ev(0, c_EV_KICK, s + 11, 1);
    push_ev(0, c_EV_SHIFT, s + 12, 1);
    push_ev(0, c_EV_LDONE, s + 13, 1);
    push_st(s + 14, 1'b1, 1'b0, 0, 24'h100, 24'h11, 5'b00000);
    tick(); start_a = 1'b0;
    wait_until(s + 13); abort_a = 1'b1;
    tick(); abort_a = 1'b0;
    wait_until(s + 30);
`endif

    fin = 1'b1;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got no end of test, required completion within 50000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
